me_pixel_feeder: RTL and testbench

// - Upstream feeder for the `me` motion-estimation core.
// - Buffers one current macroblock (MACRO_DIM^2) and one search window (SEARCH_DIM^2), loaded one pixel per cycle.
// - Streams column slices to `me` whenever `me` asserts en_ram: 17 search-window pixels and 16 current-MB pixels per beat.

---
 rtl/me_pkg.sv | 27 ++
 rtl/me_pixel_bank.sv | 36 +++
 rtl/me_pixel_feeder.sv | 177 +++++++++++++++++
 tb/tb_me_pixel_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation pixel feeder.
// - PIX_W / MACRO_DIM / SEARCH_DIM : pixel width and block geometry
// - PORT_WIDTH : search pixels delivered per beat (one more than a macroblock edge)
// - NUM_BANDS  : row bands needed to cover the search window at PORT_WIDTH rows per band
// - pixel_t, feed_state_e : pixel type and feeder FSM states
package me_pkg;

  localparam int PIX_W      = 8;
  localparam int MACRO_DIM  = 16;
  localparam int SEARCH_DIM = 48;
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NUM_BANDS  = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int SRCH_DEPTH = NUM_BANDS * SEARCH_DIM;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    FEED_IDLE   = 1'b0,
    FEED_STREAM = 1'b1
  } feed_state_e;

  // Address/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/me_pixel_bank.sv
// One-write / one-read synchronous pixel RAM.
// - clk           : clock
// - we/waddr/wdata: write port, lands on posedge
// - re/raddr      : read request; rdata updates on the posedge where re=1
//                   and holds its value otherwise
// No reset on the storage or read register so the array maps onto block RAM.
module me_pixel_bank
  import me_pkg::*;
#(
  parameter int DEPTH = 48,
  localparam int AW = clog2_min1(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [0:DEPTH-1];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/me_pixel_feeder.sv
// Upstream feeder for the motion-estimation core.
// Holds one current macroblock and one search window, loaded a pixel per
// cycle while idle, then streams column slices (PORT_WIDTH search pixels,
// MACRO_DIM current pixels) each cycle the core raises en_ram.
// - clk, rst_n      : clock, asynchronous active-low reset
// - wr_en/wr_sel    : pixel write strobe; sel 0 = current MB, 1 = search window
// - wr_row/wr_col   : pixel coordinates, out-of-range writes are dropped
// - wr_data         : pixel value
// - arm             : start a stream pass (ignored while streaming)
// - en_ram          : advance one beat this cycle
// - pixel_spr_out   : search column slice, pixel_cpr_out : current column slice
// - out_valid       : outputs carry a fresh beat
// - busy            : stream pass in progress
// - feed_done       : marks the final beat of a pass
module me_pixel_feeder
  import me_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [5:0]         wr_row,
  input  logic [5:0]         wr_col,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               arm,
  input  logic               en_ram,
  output logic [PIX_W-1:0]   pixel_spr_out [0:PORT_WIDTH-1],
  output logic [PIX_W-1:0]   pixel_cpr_out [0:MACRO_DIM-1],
  output logic               out_valid,
  output logic               busy,
  output logic               feed_done
);

  localparam int COL_W   = clog2_min1(SEARCH_DIM);
  localparam int BAND_W  = clog2_min1(NUM_BANDS);
  localparam int SADDR_W = clog2_min1(SRCH_DEPTH);
  localparam int SBANK_W = clog2_min1(PORT_WIDTH);
  localparam int CADDR_W = clog2_min1(MACRO_DIM);
  localparam int CBANK_W = clog2_min1(MACRO_DIM);

  feed_state_e               state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [BAND_W-1:0]         band_q, band_d;
  logic                      out_valid_q, out_valid_d;
  logic                      feed_done_q, feed_done_d;
  // has_data gates the RAM read registers so outputs read zero out of reset.
  logic                      has_data_q, has_data_d;
  // zero marks lanes whose row lies past the bottom of the search window.
  logic [PORT_WIDTH-1:0]     zero_q, zero_d;
  logic                      rd_en;

  logic                      srch_we, cur_we;
  logic [SBANK_W-1:0]        srch_bank;
  logic [SADDR_W-1:0]        srch_waddr, srch_raddr;
  logic [CBANK_W-1:0]        cur_bank;
  logic [CADDR_W-1:0]        cur_waddr, cur_raddr;
  pixel_t                    srch_rdata [PORT_WIDTH];
  pixel_t                    cur_rdata  [MACRO_DIM];

  // Write decode: rows are interleaved across banks so that one beat reads
  // PORT_WIDTH consecutive rows of a column from distinct banks.
  always_comb begin
    srch_we    = 1'b0;
    cur_we     = 1'b0;
    srch_bank  = SBANK_W'(int'(wr_row) % PORT_WIDTH);
    srch_waddr = SADDR_W'((int'(wr_row) / PORT_WIDTH) * SEARCH_DIM + int'(wr_col));
    cur_bank   = CBANK_W'(wr_row);
    cur_waddr  = CADDR_W'(wr_col);
    if (wr_en && (state_q == FEED_IDLE)) begin
      if (wr_sel) begin
        srch_we = (int'(wr_row) < SEARCH_DIM) && (int'(wr_col) < SEARCH_DIM);
      end else begin
        cur_we  = (int'(wr_row) < MACRO_DIM) && (int'(wr_col) < MACRO_DIM);
      end
    end
  end

  assign srch_raddr = SADDR_W'(int'(band_q) * SEARCH_DIM + int'(col_q));
  // The current macroblock repeats across the search width.
  assign cur_raddr  = CADDR_W'(int'(col_q) % MACRO_DIM);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    band_d      = band_q;
    out_valid_d = 1'b0;
    feed_done_d = 1'b0;
    has_data_d  = has_data_q;
    zero_d      = zero_q;
    rd_en       = 1'b0;
    case (state_q)
      FEED_IDLE: begin
        if (arm) begin
          state_d = FEED_STREAM;
          col_d   = '0;
          band_d  = '0;
        end
      end
      FEED_STREAM: begin
        if (en_ram) begin
          rd_en       = 1'b1;
          out_valid_d = 1'b1;
          has_data_d  = 1'b1;
          for (int k = 0; k < PORT_WIDTH; k++) begin
            zero_d[k] = (int'(band_q) * PORT_WIDTH + k) >= SEARCH_DIM;
          end
          if (band_q == BAND_W'(NUM_BANDS - 1)) begin
            band_d = '0;
            if (col_q == COL_W'(SEARCH_DIM - 1)) begin
              state_d     = FEED_IDLE;
              feed_done_d = 1'b1;
              col_d       = '0;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            band_d = band_q + 1'b1;
          end
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FEED_IDLE;
      col_q       <= '0;
      band_q      <= '0;
      out_valid_q <= 1'b0;
      feed_done_q <= 1'b0;
      has_data_q  <= 1'b0;
      zero_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      band_q      <= band_d;
      out_valid_q <= out_valid_d;
      feed_done_q <= feed_done_d;
      has_data_q  <= has_data_d;
      zero_q      <= zero_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_srch
      me_pixel_bank #(.DEPTH(SRCH_DEPTH)) u_bank (
        .clk   (clk),
        .we    (srch_we && (srch_bank == SBANK_W'(gi))),
        .waddr (srch_waddr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (srch_raddr),
        .rdata (srch_rdata[gi])
      );
      assign pixel_spr_out[gi] = (has_data_q && !zero_q[gi]) ? srch_rdata[gi] : '0;
    end
    for (gi = 0; gi < MACRO_DIM; gi++) begin : g_cur
      me_pixel_bank #(.DEPTH(MACRO_DIM)) u_bank (
        .clk   (clk),
        .we    (cur_we && (cur_bank == CBANK_W'(gi))),
        .waddr (cur_waddr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (cur_raddr),
        .rdata (cur_rdata[gi])
      );
      assign pixel_cpr_out[gi] = has_data_q ? cur_rdata[gi] : '0;
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign busy      = (state_q == FEED_STREAM);
  assign feed_done = feed_done_q;

endmodule

// File: tb/tb_me_pixel_feeder.sv
module tb_me_pixel_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel, arm, en_ram;
  logic [5:0] wr_row, wr_col;
  logic [7:0] wr_data;
  logic [7:0] spr [0:16];
  logic [7:0] cpr [0:15];
  logic       out_valid, busy, feed_done;

  int checks   = 0;
  int failures = 0;

  me_pixel_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_data       (wr_data),
    .arm           (arm),
    .en_ram        (en_ram),
    .pixel_spr_out (spr),
    .pixel_cpr_out (cpr),
    .out_valid     (out_valid),
    .busy          (busy),
    .feed_done     (feed_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference image: S[r][c]=(r*48+c)&FF, C[r][c]=(r*16+c)^A5; beat b is col b/3, band b%3.
  function automatic logic [7:0] exp_spr(input int b, input int k);
    int row;
    row = (b % 3) * 17 + k;
    if (row >= 48) return 8'h00;
    return 8'((row * 48 + b / 3) & 255);
  endfunction

  function automatic logic [7:0] exp_cpr(input int b, input int j);
    return 8'((j * 16 + (b / 3) % 16) ^ 8'hA5);
  endfunction

  task automatic chk_beat(input int b);
    for (int k = 0; k < 17; k++) chk($sformatf("b%0d_spr%0d", b, k), 32'(spr[k]), 32'(exp_spr(b, k)));
    for (int j = 0; j < 16; j++) chk($sformatf("b%0d_cpr%0d", b, j), 32'(cpr[j]), 32'(exp_cpr(b, j)));
  endtask

  initial begin
    int b, cyc;
    logic [7:0] beat0_spr [0:16];
    beat0_spr = '{8'd0, 8'd48, 8'd96, 8'd144, 8'd192, 8'd240, 8'd32, 8'd80, 8'd128,
                  8'd176, 8'd224, 8'd16, 8'd64, 8'd112, 8'd160, 8'd208, 8'd0};
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; arm = 1'b0; en_ram = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_feed_done", 32'(feed_done), 32'd0);
    chk("rst_spr0", 32'(spr[0]), 32'd0);
    chk("rst_cpr0", 32'(cpr[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load search window, then an out-of-range column that would alias S[17][2].
    wr_en = 1'b1; wr_sel = 1'b1;
    for (int r = 0; r < 48; r++)
      for (int c = 0; c < 48; c++) begin
        wr_row = 6'(r); wr_col = 6'(c); wr_data = 8'((r * 48 + c) & 255);
        tick();
      end
    wr_row = 6'd0; wr_col = 6'd50; wr_data = 8'h77; tick();
    $display("load search window done");

    // Load current MB; row 16 would alias C[0][0]; last pixel shares a cycle with arm.
    wr_sel = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (!(r == 15 && c == 15)) begin
          wr_row = 6'(r); wr_col = 6'(c); wr_data = 8'((r * 16 + c) ^ 8'hA5);
          tick();
        end
    wr_row = 6'd16; wr_col = 6'd0; wr_data = 8'h3C; tick();
    $display("load current MB done");
    wr_row = 6'd15; wr_col = 6'd15; wr_data = 8'h5A; arm = 1'b1; en_ram = 1'b1;
    tick();
    wr_en = 1'b0; arm = 1'b0;
    chk("arm_busy", 32'(busy), 32'd1);

    // Pass 1: continuous en_ram with a 3-cycle stall after beat 10 and a dropped write after beat 20.
    b = 0; cyc = 0;
    while (b < 144 && cyc < 600) begin
      tick(); cyc++;
      wr_en = 1'b0;
      if (out_valid) begin
        $display("pass1 beat %0d col %0d band %0d spr0=0x%0h cpr0=0x%0h", b, b / 3, b % 3, spr[0], cpr[0]);
        chk_beat(b);
        chk($sformatf("b%0d_feed_done", b), 32'(feed_done), (b == 143) ? 32'd1 : 32'd0);
        if (b == 0) begin
          for (int k = 0; k < 17; k++) chk($sformatf("b0_hand_spr%0d", k), 32'(spr[k]), 32'(beat0_spr[k]));
          chk("b0_hand_cpr1", 32'(cpr[1]), 32'hB5);
        end
        if (b == 2) begin
          chk("b2_hand_spr0", 32'(spr[0]), 32'd96);
          chk("b2_hand_spr13", 32'(spr[13]), 32'd208);
          chk("b2_hand_spr14", 32'(spr[14]), 32'd0);
          chk("b2_hand_spr16", 32'(spr[16]), 32'd0);
        end
        if (b == 3) begin
          chk("b3_hand_spr0", 32'(spr[0]), 32'd1);
          chk("b3_hand_cpr0", 32'(cpr[0]), 32'hA4);
        end
        if (b == 7) chk("b7_oor_alias_spr0", 32'(spr[0]), 32'h32);
        if (b == 45) chk("b45_arm_write_cpr15", 32'(cpr[15]), 32'h5A);
        if (b < 143) chk($sformatf("b%0d_busy", b), 32'(busy), 32'd1);
        if (b == 10) begin
          en_ram = 1'b0;
          for (int s = 0; s < 3; s++) begin
            tick();
            $display("stall cycle %0d out_valid=%0d", s, out_valid);
            chk($sformatf("stall%0d_out_valid", s), 32'(out_valid), 32'd0);
            chk($sformatf("stall%0d_spr0", s), 32'(spr[0]), 32'(exp_spr(10, 0)));
            chk($sformatf("stall%0d_cpr3", s), 32'(cpr[3]), 32'(exp_cpr(10, 3)));
          end
          en_ram = 1'b1;
        end
        if (b == 20) begin
          wr_en = 1'b1; wr_sel = 1'b1; wr_row = 6'd0; wr_col = 6'd0; wr_data = 8'hFF;
        end
        b++;
      end
    end
    chk("pass1_beat_count", 32'(b), 32'd144);
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_feed_done", 32'(feed_done), 32'd0);
    chk("end_out_valid", 32'(out_valid), 32'd0);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) cyc++;
    end
    chk("idle_extra_beats", 32'(cyc), 32'd0);
    $display("pass1 complete beats=%0d", b);

    // Pass 2: re-arm, check the dropped write, reset mid-stream at beat 50.
    arm = 1'b1; tick(); arm = 1'b0;
    b = 0; cyc = 0;
    while (b <= 50 && cyc < 300) begin
      tick(); cyc++;
      if (out_valid) begin
        $display("pass2 beat %0d spr0=0x%0h cpr0=0x%0h", b, spr[0], cpr[0]);
        if (b == 0) chk("rearm_dropped_write_spr0", 32'(spr[0]), 32'd0);
        if (b == 50) begin
          chk("b50_spr1", 32'(spr[1]), 32'(exp_spr(50, 1)));
          rst_n = 1'b0;
          #1;
          chk("async_rst_spr1", 32'(spr[1]), 32'd0);
          chk("async_rst_cpr0", 32'(cpr[0]), 32'd0);
          chk("async_rst_out_valid", 32'(out_valid), 32'd0);
          chk("async_rst_busy", 32'(busy), 32'd0);
        end
        b++;
      end
    end
    chk("pass2_beat_count", 32'(b), 32'd51);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_spr0", 32'(spr[0]), 32'd0);

    // Pass 3: replay beat 0 from retained RAM contents.
    arm = 1'b1; en_ram = 1'b1; tick(); arm = 1'b0;
    cyc = 0;
    do begin
      tick(); cyc++;
    end while (!out_valid && cyc < 10);
    chk("replay_valid", 32'(out_valid), 32'd1);
    $display("pass3 beat 0 spr0=0x%0h spr6=0x%0h cpr0=0x%0h", spr[0], spr[6], cpr[0]);
    chk_beat(0);
    en_ram = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
